// File: rtl/fifo_tx_framer.sv
// Pulls a length-described frame from a byte FIFO and streams it to the MAC, padding short frames.
// Data path: 1-cycle FIFO read latency into a 2-entry skid buffer; tx_ready backpressure stalls reads.
module fifo_tx_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1518,
  parameter int IFG        = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read,
  input  logic                  len_valid,
  input  logic [10:0]           len_in,
  output logic                  len_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic                  len_err,
  output logic [15:0]           frame_cnt
);

  localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
  localparam logic [15:0] GAP_LAST = 16'(IFG - 1);

  typedef enum logic [1:0] {IDLE, SEND, PAD, GAP} state_t;

  state_t                state_q, state_d;
  logic [10:0]           len_q, len_d;
  logic [10:0]           req_q, req_d;
  logic [10:0]           sent_q, sent_d;
  logic [15:0]           gap_q, gap_d;
  logic [15:0]           frame_q, frame_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]            occ_q, occ_d;
  logic                  infl_q;
  logic                  rdy_en_q;
  logic                  err_q, err_d;

  logic                  pop, pop_buf, accept, bad_len;
  logic [1:0]            occ_pop;
  logic [10:0]           last_len;

  always_comb begin
    last_len  = (len_q >= MIN_L) ? len_q : MIN_L;
    tx_valid  = ((state_q == SEND) && (occ_q != 2'd0)) || (state_q == PAD);
    tx_data   = ((state_q == SEND) && (occ_q != 2'd0)) ? buf0_q : '0;
    tx_last   = tx_valid && ((sent_q + 11'd1) == last_len);
    pop       = tx_valid && tx_ready;
    pop_buf   = pop && (state_q == SEND);
    len_ready = (state_q == IDLE) && rdy_en_q;
    accept    = len_valid && len_ready;
    bad_len   = (len_in == 11'd0) || (len_in > MAX_L);
    // Credit the byte leaving this cycle so a back-to-back stream never bubbles.
    occ_pop   = occ_q - {1'b0, pop_buf};
    fifo_read = (state_q == SEND) && !fifo_empty && (req_q < len_q) &&
                ((occ_pop + {1'b0, infl_q}) < 2'd2);
  end

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_pop;
    if (pop_buf) begin
      buf0_d = buf1_q;
    end
    if (infl_q) begin
      if (occ_pop == 2'd0) begin
        buf0_d = fifo_data;
      end else begin
        buf1_d = fifo_data;
      end
      occ_d = occ_pop + 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    req_d   = req_q;
    sent_d  = sent_q;
    gap_d   = gap_q;
    frame_d = frame_q;
    err_d   = 1'b0;
    if (pop && tx_last) begin
      frame_d = frame_q + 16'd1;
    end
    if (fifo_read) begin
      req_d = req_q + 11'd1;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bad_len) begin
            err_d = 1'b1;
          end else begin
            len_d   = len_in;
            req_d   = 11'd0;
            sent_d  = 11'd0;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (pop) begin
          sent_d = sent_q + 11'd1;
          gap_d  = 16'd0;
          if (tx_last) begin
            state_d = GAP;
          end else if ((sent_q + 11'd1) == len_q) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        if (pop) begin
          sent_d = sent_q + 11'd1;
          gap_d  = 16'd0;
          if (tx_last) begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      req_q    <= '0;
      sent_q   <= '0;
      gap_q    <= '0;
      frame_q  <= '0;
      buf0_q   <= '0;
      buf1_q   <= '0;
      occ_q    <= '0;
      infl_q   <= 1'b0;
      rdy_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      req_q    <= req_d;
      sent_q   <= sent_d;
      gap_q    <= gap_d;
      frame_q  <= frame_d;
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
      occ_q    <= occ_d;
      infl_q   <= fifo_read;
      rdy_en_q <= 1'b1;
      err_q    <= err_d;
    end
  end

  assign len_err   = err_q;
  assign frame_cnt = frame_q;

endmodule
